// File: rtl/avalon_mm_pkg.sv
// Shared types for the multi-channel Avalon-MM arbiter: FSM states, read tags
// and the round-robin selector.
package avalon_mm_pkg;

    localparam int CH_N    = 4;
    localparam int CH_W    = $clog2(CH_N);
    localparam int BURST_W = 2;

    typedef enum logic [1:0] {ARB, CMD, WR_BURST} arb_state_t;

    typedef struct packed {
        logic [CH_W-1:0]    ch;
        logic [BURST_W-1:0] burstcount;
    } rd_tag_t;

    // Walk from the farthest channel to the nearest so the nearest requester after last wins.
    function automatic logic [CH_W-1:0] rr_pick(input logic [CH_N-1:0] req,
                                                input logic [CH_W-1:0] last);
        logic [CH_W-1:0] idx;
        rr_pick = last;
        for (int k = CH_N; k >= 1; k--) begin
            idx = CH_W'((int'(last) + k) % CH_N);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/avalon_mm_sc_fifo.sv
// Single-clock FIFO holding read tags; extra pointer bit separates full from empty.
module avalon_mm_sc_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wptr[AW-1:0]] <= din;
                wptr              <= wptr + 1'b1;
            end
            if (pop && !empty) rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/avalon_mm_arbiter.sv
// Round-robin arbiter funnelling CH_CNT Avalon-MM agents onto one master port,
// with locked write bursts and in-order read-data steering via a tag FIFO.
module avalon_mm_arbiter
    import avalon_mm_pkg::*;
#(
    parameter int CH_CNT    = 4,
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 12,
    parameter int BURST_W   = 2,
    parameter int RD_DEPTH  = 8,
    localparam int DATA_B_W = DATA_W / 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CH_CNT*ADDR_W-1:0]     s_address,
    input  logic [CH_CNT*BURST_W-1:0]    s_burstcount,
    input  logic [CH_CNT*DATA_B_W-1:0]   s_byteenable,
    input  logic [CH_CNT-1:0]            s_write,
    input  logic [CH_CNT*DATA_W-1:0]     s_writedata,
    input  logic [CH_CNT-1:0]            s_read,
    output logic [CH_CNT-1:0]            s_waitrequest,
    output logic [CH_CNT-1:0]            s_readdatavalid,
    output logic [DATA_W-1:0]            s_readdata,
    output logic [ADDR_W-1:0]            m_address,
    output logic [BURST_W-1:0]           m_burstcount,
    output logic [DATA_B_W-1:0]          m_byteenable,
    output logic                         m_write,
    output logic [DATA_W-1:0]            m_writedata,
    output logic                         m_read,
    input  logic                         m_waitrequest,
    input  logic                         m_readdatavalid,
    input  logic [DATA_W-1:0]            m_readdata
);

    arb_state_t         state;
    logic [CH_W-1:0]    grant, last_grant;
    logic [BURST_W-1:0] beat_cnt, rsp_cnt, hold_bc;
    logic [ADDR_W-1:0]  hold_addr;
    logic [CH_CNT-1:0]  eligible;
    logic               accept, push, pop, rd_hit, fifo_full, fifo_empty, stray_ok;
    rd_tag_t            push_tag, head;

    assign eligible = s_write | (s_read & {CH_CNT{~fifo_full}});
    assign accept   = (m_read | m_write) & ~m_waitrequest;
    assign push     = (state == CMD) & m_read & ~m_waitrequest;
    assign push_tag = '{ch: grant, burstcount: m_burstcount};
    assign rd_hit   = m_readdatavalid & ~fifo_empty;
    assign pop      = rd_hit & ((rsp_cnt + 1'b1) == head.burstcount);

    always_comb begin
        m_address     = s_address[int'(grant)*ADDR_W +: ADDR_W];
        m_burstcount  = s_burstcount[int'(grant)*BURST_W +: BURST_W];
        m_byteenable  = s_byteenable[int'(grant)*DATA_B_W +: DATA_B_W];
        m_writedata   = s_writedata[int'(grant)*DATA_W +: DATA_W];
        m_write       = 1'b0;
        m_read        = 1'b0;
        s_waitrequest = '1;
        if (state == WR_BURST) begin
            m_address    = hold_addr;
            m_burstcount = hold_bc;
            m_write      = s_write[grant];
        end else if (state == CMD) begin
            m_write = s_write[grant];
            m_read  = s_read[grant] & ~s_write[grant];
        end
        if (state != ARB) s_waitrequest[grant] = m_waitrequest;
    end

    always_comb begin
        s_readdatavalid = '0;
        if (rd_hit) s_readdatavalid[head.ch] = 1'b1;
    end
    assign s_readdata = m_readdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ARB;
            grant      <= '0;
            last_grant <= CH_W'(CH_CNT - 1);
            beat_cnt   <= '0;
            rsp_cnt    <= '0;
            hold_addr  <= '0;
            hold_bc    <= '0;
        end else begin
            if (rd_hit) rsp_cnt <= pop ? '0 : rsp_cnt + 1'b1;
            case (state)
                ARB: if (|eligible) begin
                    grant <= rr_pick(eligible, last_grant);
                    state <= CMD;
                end
                CMD: if (accept) begin
                    last_grant <= grant;
                    if (m_write && m_burstcount > BURST_W'(1)) begin
                        beat_cnt  <= m_burstcount - 1'b1;
                        hold_addr <= m_address;
                        hold_bc   <= m_burstcount;
                        state     <= WR_BURST;
                    end else begin
                        state <= ARB;
                    end
                end else if (!s_read[grant] && !s_write[grant]) begin
                    state <= ARB;
                end
                WR_BURST: if (accept) begin
                    beat_cnt <= beat_cnt - 1'b1;
                    if (beat_cnt == BURST_W'(1)) state <= ARB;
                end
                default: state <= ARB;
            endcase
        end
    end

    avalon_mm_sc_fifo #(.W($bits(rd_tag_t)), .DEPTH(RD_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_tag),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Responses to reads dropped by a reset are expected; only unexplained ones are flagged.
    always_ff @(posedge clk) begin
        if (!rst) stray_ok <= stray_ok | ~fifo_empty;
        else if (push) stray_ok <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst && m_readdatavalid && !stray_ok)
            assert (!fifo_empty) else $error("avalon_mm_arbiter: read data with no read outstanding");
    end

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Bench for avalon_mm_arbiter: directed vector table, hand sequences, and a
// randomized multi-master run scored against a transaction-level model.
module tb_avalon_mm_arbiter;

    localparam int CH = 4, DW = 64, AW = 12, BW = 2, DEPTH = 8;

    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    logic [CH-1:0][AW-1:0]   a;
    logic [CH-1:0][BW-1:0]   bcv;
    logic [CH-1:0][DW/8-1:0] be;
    logic [CH-1:0][DW-1:0]   wd;
    logic [CH-1:0]           wr, rd, swait, srdv;
    logic [DW-1:0]           srdata, mwd, mrdata;
    logic [AW-1:0]           maddr;
    logic [BW-1:0]           mbc;
    logic [DW/8-1:0]         mbe;
    logic                    mwrite, mread, mwait, mrdv;

    int checks = 0, failures = 0;

    avalon_mm_arbiter #(.CH_CNT(CH), .DATA_W(DW), .ADDR_W(AW), .BURST_W(BW), .RD_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_address(a), .s_burstcount(bcv), .s_byteenable(be), .s_write(wr),
        .s_writedata(wd), .s_read(rd), .s_waitrequest(swait),
        .s_readdatavalid(srdv), .s_readdata(srdata),
        .m_address(maddr), .m_burstcount(mbc), .m_byteenable(mbe), .m_write(mwrite),
        .m_writedata(mwd), .m_read(mread), .m_waitrequest(mwait),
        .m_readdatavalid(mrdv), .m_readdata(mrdata)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        a = '0; bcv = {CH{2'd1}}; be = '1; wd = '0; wr = '0; rd = '0;
        mwait = 1'b0; mrdv = 1'b0; mrdata = '0;
    endtask

    task automatic reset_dut();
        clr();
        rst = 1'b0;
        nxt();
        nxt();
        rst = 1'b1;
    endtask

    // Single-beat command from one channel, held until the arbiter takes it.
    task automatic issue(input int c, input bit w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        bit ok;
        ok = 1'b0;
        a[c] = ad; bcv[c] = 2'd1; wd[c] = d; wr[c] = w; rd[c] = !w;
        for (int i = 0; i < 20 && !ok; i++) begin
            #3;
            ok = !swait[c];
            nxt();
        end
        wr[c] = 1'b0; rd[c] = 1'b0;
        chk("issue_accept", ok, 1);
    endtask

    typedef struct {
        logic [3:0]    wr;
        logic          mwait;
        logic          exp_mw;
        logic [3:0]    exp_sw;
        logic [DW-1:0] exp_wd;
    } vec_t;

    vec_t vt [14];
    logic [DW-1:0] dch [CH];

    // Randomized-run state: per-channel master, per-beat response channel queue.
    bit            act [CH];
    bit            is_wr [CH];
    int            left [CH];
    int            beats_left [CH];
    logic [AW-1:0] ma [CH];
    logic [BW-1:0] mb [CH];
    logic [DW-1:0] md [CH];
    int            exp_q [$];
    int            owed;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset and idle ----
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            #3;
            chk("idle_swait", swait, 4'hF);
            chk("idle_mread", mread, 0);
            chk("idle_mwrite", mwrite, 0);
            chk("idle_srdv", srdv, 0);
            nxt();
        end

        // ---- table: concurrent single writes, stall, round-robin wrap ----
        for (int c = 0; c < CH; c++) dch[c] = 64'hD0D0_0000_0000_0000 | 64'(c);
        vt[0]  = '{4'b0101, 0, 0, 4'b1111, '0};
        vt[1]  = '{4'b0101, 0, 1, 4'b1110, dch[0]};
        vt[2]  = '{4'b0100, 0, 0, 4'b1111, '0};
        vt[3]  = '{4'b0100, 0, 1, 4'b1011, dch[2]};
        vt[4]  = '{4'b0000, 0, 0, 4'b1111, '0};
        vt[5]  = '{4'b0010, 0, 0, 4'b1111, '0};
        vt[6]  = '{4'b0010, 1, 1, 4'b1111, dch[1]};
        vt[7]  = '{4'b0010, 0, 1, 4'b1101, dch[1]};
        vt[8]  = '{4'b0000, 0, 0, 4'b1111, '0};
        vt[9]  = '{4'b1001, 0, 0, 4'b1111, '0};
        vt[10] = '{4'b1001, 0, 1, 4'b0111, dch[3]};
        vt[11] = '{4'b0001, 0, 0, 4'b1111, '0};
        vt[12] = '{4'b0001, 0, 1, 4'b1110, dch[0]};
        vt[13] = '{4'b0000, 0, 0, 4'b1111, '0};
        reset_dut();
        for (int c = 0; c < CH; c++) begin
            wd[c] = dch[c];
            a[c]  = AW'(12'h100 + c);
        end
        for (int i = 0; i < 14; i++) begin
            wr = vt[i].wr; mwait = vt[i].mwait;
            #3;
            chk($sformatf("vec%0d_mwrite", i), mwrite, vt[i].exp_mw);
            chk($sformatf("vec%0d_mread", i), mread, 0);
            chk($sformatf("vec%0d_swait", i), swait, vt[i].exp_sw);
            if (vt[i].exp_mw) chk($sformatf("vec%0d_wdata", i), mwd, vt[i].exp_wd);
            nxt();
        end

        // ---- ch1 two-beat burst locks out ch3 read ----
        reset_dut();
        a[1] = 12'h040; bcv[1] = 2'd2; wd[1] = 64'hB0; wr[1] = 1'b1;
        a[3] = 12'h100; bcv[3] = 2'd1; rd[3] = 1'b1;
        #3; chk("burst_arb_swait", swait, 4'hF); nxt();
        #3;
        chk("burst_b0_mwrite", mwrite, 1); chk("burst_b0_addr", maddr, 12'h040);
        chk("burst_b0_bc", mbc, 2); chk("burst_b0_data", mwd, 64'hB0);
        chk("burst_b0_mread", mread, 0); chk("burst_b0_swait", swait, 4'b1101);
        nxt();
        a[1] = 12'h7FF; bcv[1] = 2'd1; wd[1] = 64'hB1;
        #3;
        chk("burst_b1_mwrite", mwrite, 1); chk("burst_b1_addr", maddr, 12'h040);
        chk("burst_b1_bc", mbc, 2); chk("burst_b1_data", mwd, 64'hB1);
        chk("burst_b1_mread", mread, 0); chk("burst_b1_swait", swait, 4'b1101);
        nxt();
        wr[1] = 1'b0;
        #3; chk("burst_end_mread", mread, 0); chk("burst_end_swait", swait, 4'hF); nxt();
        #3;
        chk("rd3_mread", mread, 1); chk("rd3_addr", maddr, 12'h100);
        chk("rd3_bc", mbc, 1); chk("rd3_swait", swait, 4'b0111);
        nxt();
        rd[3] = 1'b0; mrdv = 1'b1; mrdata = 64'h3333;
        #3; chk("rd3_srdv", srdv, 4'b1000); chk("rd3_data", srdata, 64'h3333); nxt();
        mrdv = 1'b0;

        // ---- ch0 burst-2 read then ch3 single read, three beats back ----
        a[0] = 12'h010; bcv[0] = 2'd2; rd[0] = 1'b1;
        a[3] = 12'h020; bcv[3] = 2'd1; rd[3] = 1'b1;
        #3; chk("rr_arb_swait", swait, 4'hF); nxt();
        #3;
        chk("rd0_mread", mread, 1); chk("rd0_addr", maddr, 12'h010);
        chk("rd0_bc", mbc, 2); chk("rd0_swait", swait, 4'b1110);
        nxt();
        rd[0] = 1'b0;
        #3; chk("rd_gap_mread", mread, 0); nxt();
        #3;
        chk("rd3b_mread", mread, 1); chk("rd3b_addr", maddr, 12'h020);
        chk("rd3b_swait", swait, 4'b0111);
        nxt();
        rd[3] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mrdv = 1'b1; mrdata = 64'hA0 + 64'(i);
            #3;
            chk($sformatf("rsp%0d_srdv", i), srdv, (i < 2) ? 4'b0001 : 4'b1000);
            chk($sformatf("rsp%0d_data", i), srdata, 64'hA0 + 64'(i));
            nxt();
        end
        mrdv = 1'b0;
        #3; chk("rsp_idle_srdv", srdv, 0); nxt();

        // ---- tag FIFO full: 9th read stalls, writes still flow ----
        begin
            bit got1, got2;
            for (int i = 0; i < DEPTH; i++) issue(0, 1'b0, AW'(i * 8), '0);
            a[1] = 12'h0F0; bcv[1] = 2'd1; rd[1] = 1'b1;
            a[2] = 12'h0E0; bcv[2] = 2'd1; wd[2] = 64'hCAFE; wr[2] = 1'b1;
            got2 = 1'b0;
            for (int i = 0; i < 6; i++) begin
                #3;
                chk("full_stall", swait[1], 1);
                if (!swait[2]) got2 = 1'b1;
                if (mwrite && !mwait) chk("full_wdata", mwd, 64'hCAFE);
                nxt();
                if (got2) wr[2] = 1'b0;
            end
            chk("write_while_full", got2, 1);
            mrdv = 1'b1; mrdata = 64'h55;
            #3; chk("unblock_srdv", srdv, 4'b0001); nxt();
            mrdv = 1'b0;
            got1 = 1'b0;
            for (int i = 0; i < 10 && !got1; i++) begin
                #3;
                got1 = !swait[1];
                nxt();
            end
            rd[1] = 1'b0;
            chk("read9_accept", got1, 1);
            for (int i = 0; i < DEPTH; i++) begin
                mrdv = 1'b1;
                #3; chk($sformatf("drain%0d_srdv", i), srdv, (i < DEPTH - 1) ? 4'b0001 : 4'b0010); nxt();
            end
            mrdv = 1'b0;
        end

        // ---- reset mid-burst with two reads outstanding ----
        begin
            bit ok;
            issue(0, 1'b0, 12'h300, '0);
            issue(1, 1'b0, 12'h310, '0);
            a[2] = 12'h200; bcv[2] = 2'd2; wd[2] = 64'h77; wr[2] = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 10 && !ok; i++) begin
                #3;
                ok = !swait[2];
                nxt();
            end
            chk("rst_burst_started", ok, 1);
            rst = 1'b0; mwait = 1'b1;
            #3; nxt();
            rst = 1'b1;
            clr();
            #3;
            chk("rst_state_arb", 64'(dut.state), 64'(avalon_mm_pkg::ARB));
            chk("rst_fifo_empty", dut.u_fifo.empty, 1);
            chk("rst_swait", swait, 4'hF);
            chk("rst_mwrite", mwrite, 0);
            nxt();
            mrdv = 1'b1; mrdata = 64'hDEAD;
            #3; chk("stray_srdv", srdv, 0); nxt();
            mrdv = 1'b0;
        end

        // ---- randomized masters vs. transaction model ----
        reset_dut();
        owed = 0;
        for (int c = 0; c < CH; c++) begin
            act[c] = 1'b0; left[c] = 20;
        end
        begin
            bit fin;
            fin = 1'b0;
            for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
                int nacc, g;
                logic [3:0] e;
                bit macc;
                for (int c = 0; c < CH; c++) begin
                    bit pause;
                    if (!act[c] && left[c] > 0 && $urandom_range(0, 2) == 0) begin
                        act[c] = 1'b1; is_wr[c] = 1'($urandom_range(0, 1));
                        ma[c] = AW'($urandom); mb[c] = BW'($urandom_range(1, 2));
                        beats_left[c] = int'(mb[c]); md[c] = {$urandom, $urandom};
                        left[c]--;
                    end
                    pause = act[c] && is_wr[c] && beats_left[c] < int'(mb[c]) && $urandom_range(0, 3) == 0;
                    a[c] = ma[c]; bcv[c] = mb[c]; wd[c] = md[c];
                    wr[c] = act[c] && is_wr[c] && !pause;
                    rd[c] = act[c] && !is_wr[c];
                end
                mwait = ($urandom_range(0, 3) == 0);
                mrdv = (owed > 0) && ($urandom_range(0, 1) == 1);
                mrdata = {$urandom, $urandom};
                #3;
                e = '0;
                if (mrdv) begin
                    e[exp_q.pop_front()] = 1'b1;
                    owed--;
                    chk("rnd_rdata", srdata, mrdata);
                end
                chk("rnd_srdv", srdv, e);
                nacc = 0; g = 0;
                for (int c = 0; c < CH; c++)
                    if ((wr[c] || rd[c]) && !swait[c]) begin
                        nacc++; g = c;
                    end
                macc = (mread || mwrite) && !mwait;
                chk("rnd_accept_agree", nacc, macc);
                if (nacc == 1 && macc) begin
                    chk("rnd_kind", mwrite, is_wr[g]);
                    chk("rnd_addr", maddr, ma[g]);
                    chk("rnd_bc", mbc, mb[g]);
                    if (is_wr[g]) begin
                        chk("rnd_wdata", mwd, md[g]);
                        beats_left[g]--;
                        md[g] = {$urandom, $urandom};
                        if (beats_left[g] == 0) act[g] = 1'b0;
                    end else begin
                        for (int k = 0; k < int'(mb[g]); k++) exp_q.push_back(g);
                        owed += int'(mb[g]);
                        act[g] = 1'b0;
                    end
                end
                fin = (owed == 0);
                for (int c = 0; c < CH; c++) if (act[c] || left[c] > 0) fin = 1'b0;
                nxt();
            end
            chk("rnd_all_done", fin, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
